// File: rtl/utils_pkg.sv
// Shared ASCII constants, streamer state encoding and BCD sizing helper.
package utils_pkg;

    localparam logic [7:0] ASCII_ZERO  = 8'h30;
    localparam logic [7:0] ASCII_MINUS = 8'h2D;
    localparam logic [7:0] ASCII_LF    = 8'h0A;

    typedef enum logic [2:0] {
        IDLE,
        CONVERT,
        SKIP,
        SIGN,
        EMIT,
        TERM
    } state_t;

    // Decimal digits needed to hold any w-bit unsigned value.
    function automatic int num_bcd_digits(input int w);
        int bw;
        bw = w + (w - 4) / 3 + 1;
        return (bw + 3) / 4;
    endfunction

endpackage

// File: rtl/bcd_dabble_step.sv
// One double-dabble iteration: add-3 correction on every digit >= 5, then
// shift the whole digit vector left by one, pulling bit_in into the LSB.
module bcd_dabble_step #(
    parameter int ND = 11
) (
    input  logic [ND*4-1:0] digits_in,
    input  logic            bit_in,
    output logic [ND*4-1:0] digits_out
);

    // A corrected valid digit has bit 3 set exactly when it was >= 5, so the
    // carry into the next digit is the comparison itself.
    logic [ND-1:0] carry;

    for (genvar i = 0; i < ND; i++) begin : g_dig
        logic [3:0] d;
        logic [2:0] lo;

        assign d  = digits_in[i*4 +: 4];
        assign lo = (d >= 4'd5) ? d[2:0] + 3'd3 : d[2:0];
        assign carry[i] = (d >= 4'd5);

        if (i == 0) begin : g_lsd
            assign digits_out[i*4 +: 4] = {lo, bit_in};
        end else begin : g_upper
            assign digits_out[i*4 +: 4] = {lo, carry[i-1]};
        end
    end

    logic unused_top_carry;
    assign unused_top_carry = carry[ND-1];

endmodule

// File: rtl/bin2ascii_streamer.sv
// Streams a W-bit binary value as ASCII decimal (MSD first) plus a terminator.
// Define BIN2ASCII_SIGNED_EN to treat in_data as two's complement with a '-' prefix.
module bin2ascii_streamer
    import utils_pkg::*;
#(
    parameter int         W         = 32,
    parameter logic [7:0] TERM_CHAR = ASCII_LF
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [7:0]   out_data,
    output logic         out_last,
    output logic         busy
);

    localparam int ND = num_bcd_digits(W);
    localparam int CW = $clog2(W + 1);
    localparam int DW = $clog2(ND + 1);

    state_t          state, state_nxt;
    logic [W-1:0]    bin, bin_nxt, mag;
    logic [ND*4-1:0] bcd, bcd_nxt, bcd_step, bcd_shl;
    logic [CW-1:0]   cnt, cnt_nxt;
    logic [DW-1:0]   dcnt, dcnt_nxt;
    logic            out_valid_nxt, out_last_nxt;
    logic [7:0]      out_data_nxt;
    logic [3:0]      top_digit, next_digit;

    assign top_digit  = bcd[ND*4-1 -: 4];
    assign next_digit = bcd[ND*4-5 -: 4];
    assign bcd_shl    = {bcd[ND*4-5:0], 4'd0};

    assign in_ready = (state == IDLE);
    assign busy     = (state != IDLE);

    bcd_dabble_step #(.ND(ND)) u_step (
        .digits_in  (bcd),
        .bit_in     (bin[W-1]),
        .digits_out (bcd_step)
    );

`ifdef BIN2ASCII_SIGNED_EN
    logic neg, neg_nxt;
    // Negation in W bits keeps the most-negative value correct as unsigned.
    assign mag = in_data[W-1] ? (~in_data + W'(1)) : in_data;
`else
    assign mag = in_data;
`endif

    always_comb begin
        state_nxt     = state;
        bin_nxt       = bin;
        bcd_nxt       = bcd;
        cnt_nxt       = cnt;
        dcnt_nxt      = dcnt;
        out_valid_nxt = out_valid;
        out_data_nxt  = out_data;
        out_last_nxt  = out_last;
`ifdef BIN2ASCII_SIGNED_EN
        neg_nxt       = neg;
`endif
        case (state)
            IDLE: begin
                if (in_valid) begin
                    state_nxt = CONVERT;
                    bin_nxt   = mag;
                    bcd_nxt   = '0;
                    cnt_nxt   = CW'(W);
                    dcnt_nxt  = DW'(ND);
`ifdef BIN2ASCII_SIGNED_EN
                    neg_nxt   = in_data[W-1];
`endif
                end
            end
            CONVERT: begin
                bcd_nxt = bcd_step;
                bin_nxt = {bin[W-2:0], 1'b0};
                cnt_nxt = cnt - CW'(1);
                if (cnt == CW'(1))
                    state_nxt = SKIP;
            end
            SKIP: begin
                if (top_digit == 4'd0 && dcnt > DW'(1)) begin
                    bcd_nxt  = bcd_shl;
                    dcnt_nxt = dcnt - DW'(1);
                end else begin
                    out_valid_nxt = 1'b1;
`ifdef BIN2ASCII_SIGNED_EN
                    if (neg) begin
                        state_nxt    = SIGN;
                        out_data_nxt = ASCII_MINUS;
                    end else begin
`else
                    begin
`endif
                        state_nxt    = EMIT;
                        out_data_nxt = ASCII_ZERO + {4'd0, top_digit};
                    end
                end
            end
`ifdef BIN2ASCII_SIGNED_EN
            SIGN: begin
                if (out_ready) begin
                    state_nxt    = EMIT;
                    out_data_nxt = ASCII_ZERO + {4'd0, top_digit};
                end
            end
`endif
            // out_valid is already high here, so out_ready alone is the handshake.
            EMIT: begin
                if (out_ready) begin
                    if (dcnt == DW'(1)) begin
                        state_nxt    = TERM;
                        out_data_nxt = TERM_CHAR;
                        out_last_nxt = 1'b1;
                    end else begin
                        bcd_nxt      = bcd_shl;
                        dcnt_nxt     = dcnt - DW'(1);
                        out_data_nxt = ASCII_ZERO + {4'd0, next_digit};
                    end
                end
            end
            TERM: begin
                if (out_ready) begin
                    state_nxt     = IDLE;
                    out_valid_nxt = 1'b0;
                    out_last_nxt  = 1'b0;
                    out_data_nxt  = '0;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= IDLE;
            bin       <= '0;
            bcd       <= '0;
            cnt       <= '0;
            dcnt      <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
`ifdef BIN2ASCII_SIGNED_EN
            neg       <= 1'b0;
`endif
        end else begin
            state     <= state_nxt;
            bin       <= bin_nxt;
            bcd       <= bcd_nxt;
            cnt       <= cnt_nxt;
            dcnt      <= dcnt_nxt;
            out_valid <= out_valid_nxt;
            out_data  <= out_data_nxt;
            out_last  <= out_last_nxt;
`ifdef BIN2ASCII_SIGNED_EN
            neg       <= neg_nxt;
`endif
        end
    end

endmodule

// File: tb/tb_bin2ascii_streamer.sv
// Directed bench for bin2ascii_streamer: vector table plus reset/back-to-back sequences.
module tb_bin2ascii_streamer;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_data = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [7:0]  out_data;
    logic        out_last;
    logic        busy;

    int n_checks = 0;
    int n_errors = 0;

    bin2ascii_streamer dut (
        .clock     (clock),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .busy      (busy)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [31:0] val;
        string       txt;
        int          k;
        bit          rnd;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Presents v for one accept edge; returns just after that edge.
    task automatic send(input logic [31:0] v);
        @(negedge clock);
        chk("in_ready before accept", in_ready, 1);
        in_valid = 1'b1;
        in_data  = v;
        @(posedge clock);
        #1;
        in_valid = 1'b0;
        chk("busy after accept", busy, 1);
    endtask

    // Called just after the accept edge; collects txt followed by LF.
    task automatic receive(input string txt, input int k, input bit rnd);
        int         lat = 0;
        int         idx = 0;
        int         cyc = 0;
        int         len = txt.len();
        bit         stalled = 0;
        logic [7:0] held = '0;
        logic [7:0] exp_ch;
        while (!out_valid && lat < 200) begin
            @(posedge clock);
            #1;
            lat++;
        end
        chk($sformatf("first out_valid latency '%s'", txt), lat, 32 + k + 1);
        while (idx <= len && cyc < 400) begin
            out_ready = rnd ? ((cyc == 0) ? 1'b0 : 1'($urandom_range(0, 1))) : 1'b1;
            if (stalled) begin
                chk("out_valid held under stall", out_valid, 1);
                chk("out_data stable under stall", out_data, held);
            end
            if (!rnd)
                chk($sformatf("one char per cycle '%s' idx %0d", txt, idx), out_valid, 1);
            if (out_valid && out_ready) begin
                exp_ch = (idx == len) ? 8'h0A : txt[idx];
                chk($sformatf("char '%s' idx %0d", txt, idx), out_data, exp_ch);
                chk($sformatf("out_last '%s' idx %0d", txt, idx), out_last, (idx == len));
                idx++;
            end
            stalled = out_valid && !out_ready;
            held    = out_data;
            @(posedge clock);
            #1;
            cyc++;
        end
        chk($sformatf("stream complete '%s'", txt), idx, len + 1);
        out_ready = 1'b0;
        chk("out_valid low after term", out_valid, 0);
        chk("in_ready after term", in_ready, 1);
        chk("busy low after term", busy, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vec_t vecs[7];
        int   wait_cyc;

        vecs[0] = '{32'd1234, "1234", 7, 1'b0};
        vecs[1] = '{32'd0, "0", 10, 1'b0};
        vecs[2] = '{32'd907, "907", 8, 1'b1};
        vecs[3] = '{32'd9, "9", 10, 1'b0};
`ifdef BIN2ASCII_SIGNED_EN
        vecs[4] = '{32'hFFFFFFFF, "-1", 10, 1'b0};
        vecs[5] = '{32'hFFFFFFFB, "-5", 10, 1'b1};
        vecs[6] = '{32'h80000000, "-2147483648", 1, 1'b0};
`else
        vecs[4] = '{32'hFFFFFFFF, "4294967295", 1, 1'b0};
        vecs[5] = '{32'hFFFFFFFB, "4294967291", 1, 1'b1};
        vecs[6] = '{32'h80000000, "2147483648", 1, 1'b0};
`endif

        // Reset state
        repeat (3) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        @(posedge clock);
        #1;
        chk("reset out_valid", out_valid, 0);
        chk("reset out_data", out_data, 0);
        chk("reset out_last", out_last, 0);
        chk("reset busy", busy, 0);
        chk("reset in_ready", in_ready, 1);

        for (int i = 0; i < 7; i++) begin
            send(vecs[i].val);
            receive(vecs[i].txt, vecs[i].k, vecs[i].rnd);
        end

        // in_valid held high: second value only taken after the TERM handshake
        @(negedge clock);
        in_valid = 1'b1;
        in_data  = 32'd12;
        @(posedge clock);
        #1;
        in_data = 32'd99;
        chk("busy while valid held", busy, 1);
        chk("in_ready low while busy", in_ready, 0);
        receive("12", 9, 1'b0);
        @(posedge clock);
        #1;
        in_valid = 1'b0;
        chk("back-to-back accept", busy, 1);
        receive("99", 9, 1'b0);

        // Reset in the middle of emitting 555
        send(32'd555);
        wait_cyc = 0;
        while (!out_valid && wait_cyc < 200) begin
            @(posedge clock);
            #1;
            wait_cyc++;
        end
        chk("555 first out_valid", out_valid, 1);
        chk("555 first char", out_data, 8'h35);
        out_ready = 1'b1;
        @(posedge clock);
        #1;
        chk("555 second char", out_data, 8'h35);
        reset = 1'b1;
        @(posedge clock);
        #1;
        chk("mid-emit reset out_valid", out_valid, 0);
        chk("mid-emit reset busy", busy, 0);
        chk("mid-emit reset in_ready", in_ready, 1);
        chk("mid-emit reset out_last", out_last, 0);
        reset     = 1'b0;
        out_ready = 1'b0;
        send(32'd7);
        receive("7", 10, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
